dbg_bus_initiator: RTL



---
 rtl/dbg_bus_initiator.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/dbg_bus_initiator.sv
// dbg_bus_initiator
//
// Debug-side bus initiator. Takes single read/write commands from the debug
// transport and runs each one as a femto data-bus transaction. Only one
// transaction is outstanding at a time. The address auto-increments after
// every successful access, which lets the debugger stream blocks without
// resending the address. Each command returns OK, FAULT or (optionally)
// TIMEOUT.
//
// Handshakes (command and response side): a transfer happens on a rising
// clk edge where valid and ready are both high. The initiator of a transfer
// holds valid and its payload stable until that edge. The receiver may
// change ready at any time, and ready never depends combinationally on valid.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cmd_valid/ready   command handshake
//   cmd_addr_set      1 = load cmd_addr; 0 = use the auto-incremented address
//   cmd_addr          byte address
//   cmd_w_rb          1 = write, 0 = read
//   cmd_acc           access size code (1B / 2B / 4B)
//   cmd_wdata         write data, forwarded unmodified
//   rsp_valid/ready   response handshake
//   rsp_rdata         read data (0 for writes, faults and timeouts)
//   rsp_status        2'b00 OK, 2'b01 FAULT, 2'b10 TIMEOUT
//   busy              high whenever the FSM is not idle
//   addr/w_rb/acc/wdata/req   bus request (all registered)
//   rdata/resp/fault  bus response
//   dbg_state         current FSM state (0 IDLE, 1 REQ, 2 RSP)
//
// Build option: define DBG_BUS_TIMEOUT_EN to abort a request after
// TIMEOUT_CYCLES cycles without resp/fault. Without it, REQ waits forever.

module dbg_bus_initiator #(
    parameter int XLEN           = 32,
    parameter int BUS_WIDTH      = 32,
    parameter int BUS_ACC_CNT    = 3,
    parameter int BUS_ACC_1B     = 0,
    parameter int BUS_ACC_2B     = 1,
    parameter int BUS_ACC_4B     = 2,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int ACC_W         = $clog2(BUS_ACC_CNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_addr_set,
    input  logic [XLEN-1:0]      cmd_addr,
    input  logic                 cmd_w_rb,
    input  logic [ACC_W-1:0]     cmd_acc,
    input  logic [BUS_WIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BUS_WIDTH-1:0] rsp_rdata,
    output logic [1:0]           rsp_status,
    output logic                 busy,
    output logic [XLEN-1:0]      addr,
    output logic                 w_rb,
    output logic [ACC_W-1:0]     acc,
    output logic [BUS_WIDTH-1:0] wdata,
    output logic                 req,
    input  logic [BUS_WIDTH-1:0] rdata,
    input  logic                 resp,
    input  logic                 fault,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_FAULT   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    state_t state, state_next;

    logic                 cmd_ready_q;
    logic                 rsp_valid_q;
    logic [BUS_WIDTH-1:0] rsp_rdata_q;
    logic [1:0]           rsp_status_q;
    logic [XLEN-1:0]      addr_q;
    logic [XLEN-1:0]      auto_addr;
    logic                 w_rb_q;
    logic [ACC_W-1:0]     acc_q;
    logic [BUS_WIDTH-1:0] wdata_q;
    logic                 req_q;

    logic            accept;
    logic            done_ok;
    logic            done_fault;
    logic            done_to;
    logic            to_hit;
    logic [XLEN-1:0] addr_inc;
    logic [XLEN-1:0] start_addr;

`ifdef DBG_BUS_TIMEOUT_EN
    // Counts REQ cycles already spent without a response; the abort fires
    // in the cycle that would make the count reach TIMEOUT_CYCLES, so req
    // is high for exactly TIMEOUT_CYCLES cycles.
    logic [7:0] to_cnt;

    assign to_hit = ((to_cnt + 8'd1) == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= 8'd0;
        end else if (accept) begin
            to_cnt <= 8'd0;
        end else if (state == S_REQ) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    // No timeout hardware: TIMEOUT_CYCLES is at least 1, so this is 0.
    assign to_hit = (TIMEOUT_CYCLES == 0);
`endif

    // Unknown size codes advance the address by nothing.
    always_comb begin
        addr_inc = '0;
        case (acc_q)
            ACC_W'(BUS_ACC_1B): addr_inc = XLEN'(1);
            ACC_W'(BUS_ACC_2B): addr_inc = XLEN'(2);
            ACC_W'(BUS_ACC_4B): addr_inc = XLEN'(4);
            default:            addr_inc = '0;
        endcase
    end

    assign start_addr = cmd_addr_set ? cmd_addr : auto_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // fault has priority over resp; bus responses outside REQ are ignored.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done_ok    = 1'b0;
        done_fault = 1'b0;
        done_to    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    accept     = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (fault) begin
                    done_fault = 1'b1;
                    state_next = S_RSP;
                end else if (resp) begin
                    done_ok    = 1'b1;
                    state_next = S_RSP;
                end else if (to_hit) begin
                    done_to    = 1'b1;
                    state_next = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_status_q <= ST_OK;
            addr_q       <= '0;
            auto_addr    <= '0;
            w_rb_q       <= 1'b0;
            acc_q        <= '0;
            wdata_q      <= '0;
            req_q        <= 1'b0;
        end else begin
            // Registered so a new command is taken no earlier than the
            // cycle after the response handshake.
            cmd_ready_q <= (state_next == S_IDLE);

            if (accept) begin
                addr_q    <= start_addr;
                auto_addr <= start_addr;
                w_rb_q    <= cmd_w_rb;
                acc_q     <= cmd_acc;
                wdata_q   <= cmd_wdata;
                req_q     <= 1'b1;
            end

            if (done_ok) begin
                req_q        <= 1'b0;
                rsp_valid_q  <= 1'b1;
                rsp_status_q <= ST_OK;
                rsp_rdata_q  <= w_rb_q ? '0 : rdata;
                auto_addr    <= addr_q + addr_inc;
            end

            if (done_fault || done_to) begin
                req_q        <= 1'b0;
                rsp_valid_q  <= 1'b1;
                rsp_status_q <= done_fault ? ST_FAULT : ST_TIMEOUT;
                rsp_rdata_q  <= '0;
            end

            if (state == S_RSP && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_status = rsp_status_q;
    assign busy       = (state != S_IDLE);
    assign addr       = addr_q;
    assign w_rb       = w_rb_q;
    assign acc        = acc_q;
    assign wdata      = wdata_q;
    assign req        = req_q;
    assign dbg_state  = state;

endmodule
